// File: rtl/imm_encoder.sv
// imm_encoder: packs decoded instruction fields plus a signed immediate into an
// RV32I word after range/alignment checks, then writes the word to sequential
// instruction-memory addresses starting at BASE.
module imm_encoder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BASE   = 0,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        src,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [1:0] SRC_I = 2'd0;
    localparam logic [1:0] SRC_S = 2'd1;
    localparam logic [1:0] SRC_B = 2'd2;
    localparam logic [1:0] SRC_J = 2'd3;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_RANGE = 2'b01;
    localparam logic [1:0] CODE_ALIGN = 2'b10;
    localparam logic [1:0] CODE_FULL  = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic [31:0]        enc_word;
    logic [1:0]         chk_code;
    logic signed [31:0] simm;
    logic               out_of_range;
    logic               accept;

    assign simm   = imm;
    assign accept = in_valid && (state_q == S_RUN);

    // Place immediate bits into the format-specific instruction slots
    always_comb begin
        enc_word = '0;
        unique case (src)
            SRC_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            SRC_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            SRC_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            SRC_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: enc_word = '0;
        endcase
    end

    // Acceptance checks; full beats misaligned beats range
    always_comb begin
        out_of_range = 1'b0;
        unique case (src)
            SRC_I, SRC_S: out_of_range = (simm < -32'sd2048) || (simm > 32'sd2047);
            SRC_B:        out_of_range = (simm < -32'sd4096) || (simm > 32'sd4094);
            SRC_J:        out_of_range = (simm < -32'sd1048576) || (simm > 32'sd1048574);
            default:      out_of_range = 1'b0;
        endcase
        if (count_q == (ADDR_W+1)'(DEPTH)) begin
            chk_code = CODE_FULL;
        end else if (src[1] && imm[0]) begin
            chk_code = CODE_ALIGN;
        end else if (out_of_range) begin
            chk_code = CODE_RANGE;
        end else begin
            chk_code = CODE_NONE;
        end
    end

    // Next-state logic for the load sequencer
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_RUN;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = CODE_NONE;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (chk_code == CODE_NONE) begin
                        state_d = S_WRITE;
                        addr_d  = ADDR_W'(BASE) + count_q[ADDR_W-1:0];
                        wdata_d = enc_word;
                        last_d  = last;
                    end else begin
                        // Rejected word is dropped; memory-side registers keep old values
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = chk_code;
                    end
                end
            end
            S_WRITE: begin
                count_d = count_q + 1'b1;
                if (last_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= CODE_NONE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: transaction-level model (field packing, range rules,
// extender round-trip) with a per-cycle write monitor, plus fixed test vectors.
module tb_imm_encoder;

    localparam int unsigned AW = 9;
    localparam int unsigned BS = 16;
    localparam int unsigned DP = 256;

    logic          clk, rst_n, start, in_valid, last;
    logic [1:0]    src;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          in_ready, mem_we, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic [1:0]    err_code;
    logic          in_ready2, mem_we2, done2, err2;
    logic [3:0]    mem_addr2;
    logic [31:0]   mem_wdata2;
    logic [4:0]    count2;
    logic [1:0]    err_code2;

    imm_encoder #(.ADDR_W(AW), .BASE(BS), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .src(src), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .last(last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .done(done), .err(err), .err_code(err_code)
    );

    imm_encoder #(.ADDR_W(4), .BASE(3), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .src(src), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .last(last), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .count(count2), .done(done2), .err(err2),
        .err_code(err_code2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;
    int mcount = 0;
    bit merr = 0;
    bit d2_on = 0;
    int w2cnt = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing straight from the format tables
    function automatic logic [31:0] m_enc(input logic [1:0] s, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [4:0] d,
                                          input logic [4:0] r1, input logic [4:0] r2,
                                          input logic [31:0] im);
        case (s)
            2'd0: return {im[11:0], r1, f3, d, op};
            2'd1: return {im[11:5], r2, r1, f3, im[4:0], op};
            2'd2: return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], op};
            default: return {im[20], im[10:1], im[11], im[19:12], d, op};
        endcase
    endfunction

    // Datapath immediate extender: recovers the immediate from an instruction word
    function automatic logic [31:0] m_ext(input logic [1:0] s, input logic [31:0] w);
        case (s)
            2'd0: return {{20{w[31]}}, w[31:20]};
            2'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [1:0] m_code(input logic [1:0] s, input logic [31:0] im,
                                          input int cnt);
        int v;
        int lo, hi;
        v = im;
        if (s == 2'd0 || s == 2'd1) begin lo = -2048; hi = 2047; end
        else if (s == 2'd2) begin lo = -4096; hi = 4094; end
        else begin lo = -1048576; hi = 1048574; end
        if (cnt == DP) return 2'b11;
        if (s >= 2'd2 && (v % 2 != 0)) return 2'b10;
        if (v < lo || v > hi) return 2'b01;
        return 2'b00;
    endfunction

    // Write monitor: every mem_we cycle must match the next expected write
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_data_q.size() == 0) begin
                chk("unexpected_we", mem_we, 0);
            end else begin
                chk("wr_addr", mem_addr, exp_addr_q.pop_front());
                chk("wr_data", mem_wdata, exp_data_q.pop_front());
            end
        end
        if (mem_we2 && d2_on) begin
            chk("d2_addr", mem_addr2, 4'(3 + w2cnt));
            w2cnt++;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mcount = 0;
        merr = 0;
        chk("start_count", count, 0);
        chk("start_flags", {done, err, err_code, in_ready}, 5'b00001);
    endtask

    task automatic send(input logic [1:0] s, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] im, input logic lst);
        int n;
        logic [1:0] code;
        logic [31:0] w;
        src = s; opcode = op; funct3 = f3; rd = d; rs1 = r1; rs2 = r2; imm = im; last = lst;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 8) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            chk("ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        code = m_code(s, im, mcount);
        w = m_enc(s, op, f3, d, r1, r2, im);
        if (code == 2'b00) begin
            exp_addr_q.push_back(AW'(BS + mcount));
            exp_data_q.push_back(w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (code != 2'b00) begin
            chk("err_flag", err, 1);
            chk("err_code", err_code, code);
            chk("rdy_after_err", in_ready, 0);
            merr = 1;
        end else begin
            chk("we_pulse", mem_we, 1);
            chk("rdy_in_write", in_ready, 0);
            chk("roundtrip", m_ext(s, mem_wdata), im);
            mcount++;
            if (lst) begin
                @(posedge clk); #1;
                chk("done", done, 1);
                chk("done_count", count, mcount);
                chk("done_rdy", in_ready, 0);
            end
        end
    endtask

    task automatic rand_imm(input logic [1:0] s, input int i, output logic [31:0] im);
        int v;
        if (s <= 2'd1) begin
            v = (i == 0) ? -2048 : (i == 1) ? 2047 : int'($urandom_range(0, 4095)) - 2048;
        end else if (s == 2'd2) begin
            v = (i == 0) ? -4096 : (i == 1) ? 4094 : 2 * (int'($urandom_range(0, 4095)) - 2048);
        end else begin
            v = (i == 0) ? -1048576 : (i == 1) ? 1048574
                : 2 * (int'($urandom_range(0, 1048575)) - 524288);
        end
        im = v;
    endtask

    initial begin
        logic [31:0] im;
        logic [1:0]  s;
        int k;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0;
        src = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;

        // Pin the model against hand-computed words
        chk("model_addi", m_enc(0, 7'h13, 0, 5, 0, 0, 100), 32'h06400293);
        chk("model_sw",   m_enc(1, 7'h23, 2, 0, 0, 5, 4), 32'h00502223);
        chk("model_beq",  m_enc(2, 7'h63, 0, 0, 1, 2, 16), 32'h00208863);
        chk("model_jal",  m_enc(3, 7'h6F, 0, 1, 0, 0, 1024), 32'h400000EF);

        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_outs", {in_ready, mem_we, mem_addr, mem_wdata, count, done, err, err_code},
            '0);
        chk("rst_outs2", {in_ready2, mem_we2, count2, err2}, '0);

        // DEPTH=2 instance fills up on the third handshake
        do_start();
        d2_on = 1; w2cnt = 0;
        for (int i = 0; i < 3; i++) send(0, 7'h13, 0, 5'(i + 1), 0, 0, 32'(i), 0);
        chk("d2_writes", w2cnt, 2);
        chk("d2_err", {err2, err_code2}, 3'b111);
        chk("d2_count", count2, 2);
        d2_on = 0;
        // start while in RUN is ignored
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        chk("start_in_run_cnt", count, 3);
        chk("start_in_run_rdy", in_ready, 1);
        send(0, 7'h13, 0, 1, 0, 0, 7, 1);

        // ADDI x5, x0, 100
        do_start();
        send(0, 7'h13, 0, 5, 0, 0, 100, 1);
        chk("addi_data", mem_wdata, 32'h06400293);
        chk("addi_addr", mem_addr, BS);

        // SW / BEQ / JAL back to back
        do_start();
        send(1, 7'h23, 2, 0, 0, 5, 4, 0);
        send(2, 7'h63, 0, 0, 1, 2, 16, 0);
        send(3, 7'h6F, 0, 1, 0, 0, 1024, 1);
        chk("jal_data", mem_wdata, 32'h400000EF);
        chk("jal_addr", mem_addr, BS + 2);

        // Error cases
        do_start();
        send(2, 7'h63, 0, 0, 1, 2, 17, 0);
        do_start();
        send(0, 7'h13, 0, 1, 0, 0, 2048, 0);
        do_start();
        send(0, 7'h13, 0, 1, 0, 0, -32'sd2048, 1);
        chk("neg_imm", mem_wdata[31:20], 12'h800);

        // Reset in the middle of WRITE
        do_start();
        src = 0; opcode = 7'h13; funct3 = 0; rd = 3; rs1 = 0; rs2 = 0; imm = 9; last = 0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_we", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {in_ready, mem_we, mem_addr, mem_wdata, count, done, err, err_code},
            '0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", {in_ready, count}, '0);
        end

        // Random in-range round-trips, 1000 per format
        for (int f = 0; f < 4; f++) begin
            do_start();
            for (int i = 0; i < 1000; i++) begin
                rand_imm(2'(f), i, im);
                send(2'(f), 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), im, (i % 250) == 249);
                if ((i % 250) == 249) do_start();
            end
        end

        // Random mix including out-of-range and misaligned values
        do_start();
        for (int i = 0; i < 300; i++) begin
            s = 2'($urandom);
            k = $urandom_range(0, 3);
            if (k == 0) rand_imm(s, 2, im);
            else if (k == 1) im = $urandom;
            else if (k == 2) im = 32'($urandom_range(0, 8)) + ((s == 3) ? 32'd1048570 : 32'd2042);
            else im = -(32'($urandom_range(0, 8)) + ((s == 3) ? 32'd1048572 : 32'd4092));
            send(s, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 im, (i % 50) == 49);
            if (merr || (i % 50) == 49) do_start();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_data_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Inverse of the datapath immediate extender: takes a decoded instruction (format select, opcode, register fields, 32-bit signed immediate), checks the immediate's range and alignment, and packs it into a 32-bit RV32I instruction word. It then writes the word sequentially into instruction memory. The block sits on the program-load path, ahead of the core's instruction memory. It is used by the bring-up loader and by benches that generate programs in hardware. Every written word, once fed back through the extender with the same `src`, yields the original immediate.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width.
- `BASE`, 0: first word address written after `start`.
- `DEPTH`, 256: maximum number of words written per program (1..2^ADDR_W − BASE).

Ports:
- `clk`, in, 1: single clock; all state on its rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a new program; honoured only in IDLE, DONE or ERR.
- `in_valid`, in, 1: instruction fields valid.
- `in_ready`, out, 1: block accepts this cycle.
- `src`, in, 2: format select; 0 = I, 1 = S, 2 = B, 3 = J (same coding as the extender).
- `opcode`, in, 7: opcode field.
- `funct3`, in, 3: funct3 field.
- `rd`, `rs1`, `rs2`, in, 5 each: register fields.
- `imm`, in, 32: signed immediate, byte offset for B and J.
- `last`, in, 1: final instruction of the program.
- `mem_we`, out, 1: instruction-memory write strobe.
- `mem_addr`, out, ADDR_W: word address.
- `mem_wdata`, out, 32: encoded instruction.
- `count`, out, ADDR_W+1: words written since `start`.
- `done`, out, 1: program complete.
- `err`, out, 1: sticky error flag.
- `err_code`, out, 2: 01 = range, 10 = misaligned, 11 = memory full; 00 = no error.

## Operation
FSM states are IDLE, RUN, WRITE, DONE and ERR. The reset state is IDLE.

State transitions:
- IDLE / DONE / ERR + `start` → RUN. This clears `count`, `done`, `err` and `err_code`.
- RUN: `in_ready`=1. A handshake (`in_valid`&`in_ready`) at an edge registers the encoded word and runs the checks.
  - Checks pass → WRITE.
  - Any check fails → ERR: `err`=1, `err_code` set, no write, encoded word discarded.
- WRITE: `mem_we`=1 for exactly one cycle, with `mem_addr`=BASE+`count` and `mem_wdata`=encoded word.
  - At the next edge, `count`+1.
  - Then → DONE if the accepted `last`=1 (`done`=1), else → RUN.
- DONE / ERR: `in_ready`=0 and outputs hold until `start` or reset.
- `start` in RUN or WRITE is ignored.

Encoding (`rd` ignored for S/B, `rs1`/`funct3` ignored for J, `rs2` ignored for I/J):
- I: {imm[11:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.

Checks, evaluated at acceptance. Priority is full > misaligned > range; only the highest-priority code is reported.
- Full: `count` == DEPTH → 11.
- Misaligned: B or J with imm[0]=1 → 10.
- Range, `imm` interpreted as signed 32-bit → 01:
  - I and S: outside −2048..2047.
  - B: outside −4096..4094.
  - J: outside −1048576..1048574.

Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `count`=0, `done`=0, `err`=0, `err_code`=00.

## Timing
- Throughput is one instruction per 2 cycles:
  - Handshake at edge k.
  - `mem_we` is high for the cycle between edges k and k+1; the write lands at edge k+1.
  - `in_ready` is high again after edge k+1.
- The error is visible in the cycle after the rejecting edge. `mem_we` never asserts for a rejected instruction.
- `done` rises in the cycle after the edge that writes the `last` word.
- `mem_addr` and `mem_wdata` are registered and hold their last values when `mem_we`=0. They are meaningful only while `mem_we`=1.
- `rst_n` low at any point, including during WRITE, immediately forces every output to its reset value. The in-flight write is lost.

## Test plan
- ADDI: src 0, opcode 0x13, rd 5, rs1 0, f3 0, imm 100 → one `mem_we` pulse, addr BASE, data 0x06400293, `count`=1.
- SW (src 1, opcode 0x23, f3 2, rs1 0, rs2 5, imm 4), then BEQ (src 2, opcode 0x63, f3 0, rs1 1, rs2 2, imm 16), then JAL (src 3, opcode 0x6F, rd 1, imm 1024, `last`=1), `in_valid` held high → data 0x00502223 / 0x00208863 / 0x400000EF at BASE..BASE+2, back-to-back in alternating cycles; `done`=1 and `count`=3.
- Errors:
  - B, imm 17 → `err`=1, `err_code`=10, no `mem_we`, `in_ready`=0.
  - After `start`: I, imm 2048 → 01; I, imm −2048 accepted, data[31:20]=0x800.
- DEPTH=2: three accepted instructions → two writes, then `err_code`=11 on the third handshake, `count`=2.
- Reset:
  - `rst_n` low during WRITE → `mem_we` drops without waiting for `clk`; after release the state is IDLE, `count`=0 and `in_ready` stays 0 until `start`.
  - `start` pulsed while in RUN has no effect.
- Random round-trip: 1000 random in-range, aligned immediates per format → bits [31:7] of each written word, fed through the extender with the same `src`, reproduce `imm` exactly.
